// File: rtl/shift_right_seq_8_if.sv
// Handshake bundle for the sequential right-shift unit: operand request
// channel (producer -> unit) and result channel (unit -> consumer).
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the shift unit (drives in_ready, out_valid, result, carry_out)
interface shift_right_seq_8_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic [AMT_W-1:0] shift_amount;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;

   modport master (
      output in_valid, data_in, shift_amount, mode, out_ready,
      input  in_ready, out_valid, result, carry_out
   );

   modport slave (
      input  in_valid, data_in, shift_amount, mode, out_ready,
      output in_ready, out_valid, result, carry_out
   );
endinterface

// File: rtl/shift_right_seq_8.sv
// Multi-cycle right shift / rotate unit. Takes an operand, amount and mode
// over a valid/ready handshake, shifts one position per clock, and presents
// the result plus the last bit shifted out on a second valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of shift_right_seq_8_if (request + result channels)
// Modes: 0 = LSR, 1 = ASR, 2 = ROR, 3 = reserved (behaves as LSR).
module shift_right_seq_8 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 3
) (
   input logic                clk,
   input logic                rst_n,
   shift_right_seq_8_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] MODE_ASR = 2'd1;
   localparam logic [1:0] MODE_ROR = 2'd2;

   logic [1:0]       state,     stateNext;
   logic [WIDTH-1:0] resultQ,   resultNext;
   logic             carryQ,    carryNext;
   logic [AMT_W-1:0] countQ,    countNext;
   logic [1:0]       modeQ,     modeNext;
   logic             inReadyQ;
   logic             outValidQ;
   logic             fillBit;

   // Next-state and datapath update
   always_comb begin
      stateNext  = state;
      resultNext = resultQ;
      carryNext  = carryQ;
      countNext  = countQ;
      modeNext   = modeQ;
      fillBit    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.in_valid && inReadyQ) begin
               resultNext = bus.data_in;
               countNext  = bus.shift_amount;
               modeNext   = bus.mode;
               carryNext  = 1'b0;
               stateNext  = (bus.shift_amount == '0) ? DONE : SHIFT;
            end
         end

         SHIFT: begin
            // Only entered with a non-zero count, so the decrement cannot wrap
            case (modeQ)
               MODE_ASR: fillBit = resultQ[WIDTH-1];
               MODE_ROR: fillBit = resultQ[0];
               default:  fillBit = 1'b0;
            endcase
            resultNext = {fillBit, resultQ[WIDTH-1:1]};
            carryNext  = resultQ[0];
            countNext  = countQ - AMT_W'(1);
            if (countQ == AMT_W'(1)) begin
               stateNext = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               stateNext = IDLE;
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   // State and datapath registers; handshake flags track the next state so
   // they always equal the decode of the registered state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         resultQ   <= '0;
         carryQ    <= 1'b0;
         countQ    <= '0;
         modeQ     <= '0;
         inReadyQ  <= 1'b1;
         outValidQ <= 1'b0;
      end else begin
         state     <= stateNext;
         resultQ   <= resultNext;
         carryQ    <= carryNext;
         countQ    <= countNext;
         modeQ     <= modeNext;
         inReadyQ  <= (stateNext == IDLE);
         outValidQ <= (stateNext == DONE);
      end
   end

   assign bus.in_ready  = inReadyQ;
   assign bus.out_valid = outValidQ;
   assign bus.result    = resultQ;
   assign bus.carry_out = carryQ;

endmodule

// File: tb/tb_shift_right_seq_8.sv
// Directed bench for shift_right_seq_8: shift modes, latency, backpressure
// and mid-operation reset, each compared against hand-computed values.
module tb_shift_right_seq_8;

   logic clk;
   logic rst_n;
   int   nCmp;
   int   nFail;

   shift_right_seq_8_if #(.WIDTH(8), .AMT_W(3)) bus ();

   shift_right_seq_8 #(.WIDTH(8), .AMT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation with out_ready held high; called 1ns after an edge in IDLE
   task automatic runOp(input string tag, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] expR, input logic expC);
      int lat;
      check({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.data_in      = d;
      bus.shift_amount = a;
      bus.mode         = m;
      bus.in_valid     = 1'b1;
      tick();
      bus.in_valid     = 1'b0;
      // scramble inputs: they must be ignored after accept
      bus.data_in      = ~d;
      bus.shift_amount = ~a;
      bus.mode         = m ^ 2'b01;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         check({tag, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(a) + 32'd1);
      check({tag, "_result"}, 32'(bus.result), 32'(expR));
      check({tag, "_carry"}, 32'(bus.carry_out), 32'(expC));
      check({tag, "_ready_done"}, 32'(bus.in_ready), 32'd0);
      tick();
      check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      nCmp  = 0;
      nFail = 0;
      clk   = 1'b0;
      rst_n = 1'b0;
      bus.in_valid     = 1'b0;
      bus.data_in      = '0;
      bus.shift_amount = '0;
      bus.mode         = '0;
      bus.out_ready    = 1'b1;

      #12;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_carry", 32'(bus.carry_out), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      runOp("lsr_b4_3", 8'hB4, 3'd3, 2'd0, 8'h16, 1'b1);
      runOp("asr_96_2", 8'h96, 3'd2, 2'd1, 8'hE5, 1'b1);
      runOp("asr_80_7", 8'h80, 3'd7, 2'd1, 8'hFF, 1'b0);
      runOp("asr_7f_7", 8'h7F, 3'd7, 2'd1, 8'h00, 1'b1);
      runOp("ror_81_1", 8'h81, 3'd1, 2'd2, 8'hC0, 1'b1);
      runOp("ror_01_7", 8'h01, 3'd7, 2'd2, 8'h02, 1'b0);
      runOp("lsr_80_7", 8'h80, 3'd7, 2'd0, 8'h01, 1'b0);
      runOp("rsv_f8_4", 8'hF8, 3'd4, 2'd3, 8'h0F, 1'b1);
      runOp("amt0_lsr", 8'h5A, 3'd0, 2'd0, 8'h5A, 1'b0);
      runOp("amt0_asr", 8'h5A, 3'd0, 2'd1, 8'h5A, 1'b0);
      runOp("amt0_ror", 8'h5A, 3'd0, 2'd2, 8'h5A, 1'b0);

      // Backpressure: hold result while consumer stalls, ignore new request
      bus.out_ready    = 1'b0;
      bus.data_in      = 8'hB4;
      bus.shift_amount = 3'd3;
      bus.mode         = 2'd0;
      bus.in_valid     = 1'b1;
      tick();
      bus.data_in      = 8'h81;
      bus.shift_amount = 3'd1;
      bus.mode         = 2'd2;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
         check("bp_result_hold", 32'(bus.result), 32'h16);
         check("bp_carry_hold", 32'(bus.carry_out), 32'd1);
         check("bp_ready_low", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_idle", 32'(bus.in_ready), 32'd1);
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      check("bp_accept_busy", 32'(bus.in_ready), 32'd0);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_next_latency", 32'(lat), 32'd2);
      check("bp_next_result", 32'(bus.result), 32'hC0);
      check("bp_next_carry", 32'(bus.carry_out), 32'd1);
      tick();

      // Reset in the middle of a shift
      bus.data_in      = 8'hFF;
      bus.shift_amount = 3'd7;
      bus.mode         = 2'd0;
      bus.in_valid     = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check("mid_result", 32'(bus.result), 32'h1F);
      check("mid_valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_carry", 32'(bus.carry_out), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("abort_ready", 32'(bus.in_ready), 32'd1);
      check("abort_valid_after", 32'(bus.out_valid), 32'd0);
      runOp("post_rst", 8'h96, 3'd4, 2'd2, 8'h69, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
